// File: rtl/gates_scan_if.sv
// Operand, op-select and result bundle for gates_scan.
// The testbench or host drives the master side; the block sits on the slave side.
interface gates_scan_if #(parameter int WIDTH = 4);
  logic             load;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             scan;
  logic [WIDTH-1:0] Y;
  logic [2:0]       op_cur;
  logic             valid;
  logic             wrap;

  modport master (output load, A, B, op, scan, input  Y, op_cur, valid, wrap);
  modport slave  (input  load, A, B, op, scan, output Y, op_cur, valid, wrap);
endinterface

// File: rtl/gates_scan.sv
// Registered eight-op bitwise gate set with a manual select or an auto-scan
// mode that dwells DWELL cycles per op. A per-bit lane cell evaluates the op.
module gates_scan_lane (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    y = 1'b0;
    unique case (op)
      3'd0: y = ~a;
      3'd1: y = ~b;
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = ~(a & b);
      3'd5: y = ~(a | b);
      3'd6: y = a ^ b;
      3'd7: y = ~(a ^ b);
    endcase
  end
endmodule

module gates_scan #(
  parameter int WIDTH = 4,
  parameter int DWELL = 50000000
) (
  input  logic        clk,
  input  logic        rst,
  gates_scan_if.slave bus
);
  localparam int            CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  logic [WIDTH-1:0] a_r, b_r, y_q, y_nxt;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             scan_q, rst_q, wrap_q;
  logic [1:0]       vld_pipe;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gates_scan_lane u_lane (.op(op_q), .a(a_r[i]), .b(b_r[i]), .y(y_nxt[i]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= '0;
      b_r      <= '0;
      y_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      scan_q   <= 1'b0;
      rst_q    <= 1'b1;
      wrap_q   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      rst_q    <= 1'b0;
      scan_q   <= bus.scan;
      wrap_q   <= 1'b0;
      y_q      <= y_nxt;
      vld_pipe <= {vld_pipe[0], vld_pipe[0] | bus.load};
      if (bus.load) begin
        a_r <= bus.A;
        b_r <= bus.B;
      end
      // rst_q masks the 0->1 seen right after reset so scan restarts with a full dwell
      if (!bus.scan) begin
        op_q <= bus.op;
        cnt  <= '0;
      end else if (!scan_q && !rst_q) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt    <= '0;
        op_q   <= op_q + 3'd1;
        wrap_q <= (op_q == 3'd7);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.Y      = y_q;
  assign bus.op_cur = op_q;
  assign bus.valid  = vld_pipe[1];
  assign bus.wrap   = wrap_q;
endmodule
